// File: rtl/apple_placer_if.sv
// apple_placer_if: occupancy query handshake between the apple placer and the snake-body collision logic
interface apple_placer_if;
  logic       occ_req;
  logic [5:0] occ_x;
  logic [5:0] occ_y;
  logic       occ_ack;
  logic       occ_hit;
  modport master(output occ_req, occ_x, occ_y, input occ_ack, occ_hit);
  modport slave(input occ_req, occ_x, occ_y, output occ_ack, occ_hit);
endinterface

// File: rtl/apple_placer.sv
// apple_placer: turns LFSR samples into a wall-free, snake-free apple cell and reports its pixel position
module apple_placer #(
  parameter int CELL      = 10,
  parameter int COLS      = 64,
  parameter int ROWS      = 48,
  parameter int MAX_TRIES = 16
) (
  input  logic                 VGA_clk,
  input  logic                 reset,
  input  logic [9:0]           randX,
  input  logic [8:0]           randY,
  input  logic                 spawn_req,
  apple_placer_if.master       occ,
  output logic [9:0]           appleX,
  output logic [8:0]           appleY,
  output logic                 apple_valid,
  output logic                 done,
  output logic                 fail
);
  localparam int TW = $clog2(MAX_TRIES) + 1;
  localparam logic [5:0] CMAX = 6'(COLS - 1);
  localparam logic [5:0] RMAX = 6'(ROWS - 1);
  typedef enum logic [2:0] {IDLE, SAMPLE, CHECK, WAIT_OCC, COMMIT} state_t;
  state_t state;
  logic [5:0] cand_col, cand_row;
  logic [TW-1:0] tries, next_try;
  logic legal, last;
  logic unused_rand;
  assign unused_rand = ^{randX[9:6], randY[8:6]};
  always_comb begin
    next_try = tries + TW'(1);
    last = next_try == TW'(MAX_TRIES);
    legal = cand_col != 6'd0 && cand_col < CMAX && cand_row != 6'd0 && cand_row < RMAX;
  end
  always_ff @(posedge VGA_clk) begin
    if (reset) begin
      state       <= IDLE;
      cand_col    <= '0;
      cand_row    <= '0;
      tries       <= '0;
      appleX      <= '0;
      appleY      <= '0;
      apple_valid <= 1'b0;
      done        <= 1'b0;
      fail        <= 1'b0;
      occ.occ_req <= 1'b0;
      occ.occ_x   <= '0;
      occ.occ_y   <= '0;
    end else begin
      done <= 1'b0;
      fail <= 1'b0;
      case (state)
        IDLE: if (spawn_req) begin
          state       <= SAMPLE;
          apple_valid <= 1'b0;
          tries       <= '0;
        end
        SAMPLE: begin
          cand_col <= randX[5:0];
          cand_row <= randY[5:0];
          state    <= CHECK;
        end
        CHECK: if (legal) begin
          occ.occ_req <= 1'b1;
          occ.occ_x   <= cand_col;
          occ.occ_y   <= cand_row;
          state       <= WAIT_OCC;
        end else begin
          tries <= next_try;
          fail  <= last;
          state <= last ? IDLE : SAMPLE;
        end
        WAIT_OCC: if (occ.occ_ack) begin
          occ.occ_req <= 1'b0;
          if (occ.occ_hit) begin
            tries <= next_try;
            fail  <= last;
            state <= last ? IDLE : SAMPLE;
          end else state <= COMMIT;
        end
        COMMIT: begin
          appleX      <= 10'(32'(cand_col) * CELL);
          appleY      <= 9'(32'(cand_row) * CELL);
          apple_valid <= 1'b1;
          done        <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apple_placer.sv
// tb_apple_placer: timeline model of apple placement checked against the DUT every cycle, plus directed reset checks
module tb_apple_placer;
  localparam int N = 256;
  localparam logic [9:0] RX_IDLE = 10'h3C0;
  localparam logic [8:0] RY_IDLE = 9'h1C0;
  logic clk = 1'b0, reset = 1'b1, spawn_req = 1'b0;
  logic [9:0] randX = RX_IDLE;
  logic [8:0] randY = RY_IDLE;
  logic [9:0] appleX;
  logic [8:0] appleY;
  logic apple_valid, done, fail;
  apple_placer_if occ();
  apple_placer dut(
    .VGA_clk(clk), .reset(reset), .randX(randX), .randY(randY), .spawn_req(spawn_req),
    .occ(occ), .appleX(appleX), .appleY(appleY), .apple_valid(apple_valid), .done(done), .fail(fail)
  );
  always #5 clk = ~clk;
  int errors = 0, checks = 0, cyc = 0;
  logic       e_req[N], e_done[N], e_fail[N], e_val[N];
  logic [5:0] e_x[N], e_y[N];
  logic [9:0] e_ax[N];
  logic [8:0] e_ay[N];
  logic [9:0] d_rx[N];
  logic [8:0] d_ry[N];
  logic       d_ack[N], d_hit[N], d_sp[N];
  logic [9:0] m_ax = '0;
  logic [8:0] m_ay = '0;
  logic       m_val = 1'b0;
  logic [5:0] m_ox = '0, m_oy = '0;
  logic [9:0] sc_rx[32];
  logic [8:0] sc_ry[32];
  logic       sc_hit[32];
  int         sc_del[32];
  int         sc_n = 0, sc_sp = -1, E = 0;
  task automatic check(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", nm, cyc, a, e);
    end
  endtask
  task automatic add(input logic [9:0] rx, input logic [8:0] ry, input logic hit, input int del);
    sc_rx[sc_n] = rx; sc_ry[sc_n] = ry; sc_hit[sc_n] = hit; sc_del[sc_n] = del;
    sc_n++;
  endtask
  task automatic clear();
    sc_n = 0;
    sc_sp = -1;
  endtask
  // each candidate costs SAMPLE+CHECK, plus the query wait when it reaches the collision logic
  task automatic build();
    int t, tries, q, a, e;
    logic [5:0] col, row;
    bit rej;
    for (int k = 0; k < N; k++) begin
      e_req[k] = 0; e_done[k] = 0; e_fail[k] = 0; e_val[k] = 0;
      e_x[k] = m_ox; e_y[k] = m_oy; e_ax[k] = m_ax; e_ay[k] = m_ay;
      d_rx[k] = RX_IDLE; d_ry[k] = RY_IDLE; d_ack[k] = 0; d_hit[k] = 1; d_sp[k] = 0;
    end
    d_sp[0] = 1;
    if (sc_sp >= 0) d_sp[sc_sp] = 1;
    E = -1; t = 0; tries = 0;
    for (int i = 0; i < sc_n && E < 0; i++) begin
      col = sc_rx[i][5:0];
      row = sc_ry[i][5:0];
      d_rx[t+1] = sc_rx[i];
      d_ry[t+1] = sc_ry[i];
      rej = 1;
      if (col == 0 || col >= 63 || row == 0 || row >= 47) e = t + 2;
      else begin
        q = t + 2;
        a = q + 1 + sc_del[i];
        for (int k = q; k < a; k++) e_req[k] = 1;
        for (int k = q; k < N; k++) begin e_x[k] = col; e_y[k] = row; end
        d_ack[a] = 1;
        d_hit[a] = sc_hit[i];
        e = a;
        if (!sc_hit[i]) begin
          rej = 0;
          E = a + 1;
          e_done[E] = 1;
          for (int k = E; k < N; k++) begin
            e_ax[k] = 10'(32'(col) * 10); e_ay[k] = 9'(32'(row) * 10); e_val[k] = 1;
          end
        end
      end
      if (rej) begin
        tries++;
        if (tries == 16) begin E = e; e_fail[e] = 1; end
        else t = e;
      end
    end
    if (E < 0) begin
      errors++;
      $display("FAIL model: scenario never terminates");
      E = 0;
    end
    m_ax = e_ax[N-1]; m_ay = e_ay[N-1]; m_val = e_val[N-1]; m_ox = e_x[N-1]; m_oy = e_y[N-1];
  endtask
  logic chk_on = 1'b0;
  int chk_k = 0, chk_len = 0;
  always @(posedge clk) if (chk_on) begin
    #1;
    cyc = chk_k;
    check("occ_req", 32'(occ.occ_req), 32'(e_req[chk_k]));
    check("occ_x", 32'(occ.occ_x), 32'(e_x[chk_k]));
    check("occ_y", 32'(occ.occ_y), 32'(e_y[chk_k]));
    check("done", 32'(done), 32'(e_done[chk_k]));
    check("fail", 32'(fail), 32'(e_fail[chk_k]));
    check("apple_valid", 32'(apple_valid), 32'(e_val[chk_k]));
    check("appleX", 32'(appleX), 32'(e_ax[chk_k]));
    check("appleY", 32'(appleY), 32'(e_ay[chk_k]));
    chk_k++;
    if (chk_k == chk_len) chk_on = 1'b0;
  end
  task automatic drive(input int k);
    spawn_req = d_sp[k]; randX = d_rx[k]; randY = d_ry[k];
    occ.occ_ack = d_ack[k]; occ.occ_hit = d_hit[k];
  endtask
  task automatic run();
    build();
    @(negedge clk);
    chk_k = 0; chk_len = E + 8; chk_on = 1'b1;
    drive(0);
    for (int k = 1; k < chk_len; k++) begin
      @(negedge clk);
      drive(k);
    end
    @(negedge clk);
    spawn_req = 0; randX = RX_IDLE; randY = RY_IDLE; occ.occ_ack = 0; occ.occ_hit = 0;
    if (chk_on) begin
      errors++;
      $display("FAIL checker: still active at end of scenario");
      chk_on = 1'b0;
    end
  endtask
  task automatic check_reset_outputs(input string nm);
    check({nm, "_occ_req"}, 32'(occ.occ_req), 0);
    check({nm, "_occ_x"}, 32'(occ.occ_x), 0);
    check({nm, "_occ_y"}, 32'(occ.occ_y), 0);
    check({nm, "_appleX"}, 32'(appleX), 0);
    check({nm, "_appleY"}, 32'(appleY), 0);
    check({nm, "_valid"}, 32'(apple_valid), 0);
    check({nm, "_done"}, 32'(done), 0);
    check({nm, "_fail"}, 32'(fail), 0);
  endtask
  initial begin
    occ.occ_ack = 0; occ.occ_hit = 0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    reset = 0;
    clear(); add(10'h0A5, 9'h014, 0, 0); run();
    check("pin_clean_E", 32'(E), 4);
    check("pin_clean_ax", 32'(m_ax), 370);
    check("pin_clean_ay", 32'(m_ay), 200);
    check("clean_x_dut", 32'(appleX), 370);
    check("clean_y_dut", 32'(appleY), 200);
    @(negedge clk); spawn_req = 1;
    @(negedge clk); spawn_req = 0; randX = 10'h00C; randY = 9'h00C;
    @(negedge clk); randX = RX_IDLE; randY = RY_IDLE;
    @(negedge clk);
    check("rst_pre_req", 32'(occ.occ_req), 1);
    reset = 1;
    repeat (3) @(negedge clk);
    reset = 0;
    check_reset_outputs("midrst");
    occ.occ_ack = 1; occ.occ_hit = 0;
    @(negedge clk);
    occ.occ_ack = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("late_ack_done", 32'(done), 0);
      check("late_ack_req", 32'(occ.occ_req), 0);
      check("late_ack_valid", 32'(apple_valid), 0);
      check("late_ack_appleX", 32'(appleX), 0);
    end
    m_ax = '0; m_ay = '0; m_val = 0; m_ox = '0; m_oy = '0;
    clear(); add(10'h14A, 9'h032, 0, 0); add(10'h040, 9'h00A, 0, 0); add(10'h00A, 9'h00A, 0, 0); run();
    check("pin_wall_E", 32'(E), 8);
    check("pin_wall_ax", 32'(m_ax), 100);
    check("pin_wall_ay", 32'(m_ay), 100);
    clear(); add(10'h005, 9'h005, 1, 3); add(10'h007, 9'h009, 0, 0); run();
    check("pin_occ_E", 32'(E), 10);
    check("pin_occ_ax", 32'(m_ax), 70);
    check("pin_occ_ay", 32'(m_ay), 90);
    clear(); add(10'h294, 9'h11E, 0, 4); sc_sp = 4; run();
    check("pin_busy_E", 32'(E), 8);
    check("busy_x_dut", 32'(appleX), 200);
    for (int i = 0; i < 16; i++) add(10'(i + 1), 9'(i + 1), 1, 0);
    clear();
    for (int i = 0; i < 16; i++) add(10'(i + 1), 9'(i + 1), 1, 0);
    run();
    check("pin_exh_E", 32'(E), 48);
    check("pin_exh_ax", 32'(m_ax), 200);
    check("pin_exh_ay", 32'(m_ay), 300);
    check("exh_valid_dut", 32'(apple_valid), 0);
    clear(); add(10'h03F, 9'h005, 0, 0); add(10'h005, 9'h02F, 0, 0); add(10'h03E, 9'h02E, 0, 0); run();
    check("pin_edge_E", 32'(E), 8);
    check("pin_edge_ax", 32'(m_ax), 620);
    check("pin_edge_ay", 32'(m_ay), 460);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/apple_placer.md
# apple_placer

Consumes the free-running randX/randY LFSR outputs and turns them into a legal apple position on the snake playfield grid. On each spawn request it samples random cell candidates, rejects any that land on a wall or off-grid, and asks the snake-body collision logic whether the cell is occupied. It commits the first free cell as the apple's pixel coordinates. It sits between the random generator and the game/render logic, in the VGA_clk domain.

## Interface

- CELL, 10: cell size in pixels.
- COLS, 64: grid columns. Column index is randX[5:0].
- ROWS, 48: grid rows. Row index is randY[5:0].
- MAX_TRIES, 16: rejected candidates allowed before giving up.

- VGA_clk  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- randX  in  10  random source X. Only bits [5:0] are used.
- randY  in  9  random source Y. Only bits [5:0] are used.
- spawn_req  in  1  single-cycle request for a new apple.
- occ_req  out  1  occupancy query valid.
- occ_x  out  6  queried column.
- occ_y  out  6  queried row.
- occ_ack  in  1  single-cycle query response strobe.
- occ_hit  in  1  1 = cell occupied by the snake. Valid only with occ_ack.
- appleX  out  10  apple pixel X, equal to col*CELL.
- appleY  out  9  apple pixel Y, equal to row*CELL.
- apple_valid  out  1  a committed apple is present.
- done  out  1  one-cycle pulse when placement succeeds.
- fail  out  1  one-cycle pulse when tries are exhausted.

## Operation

- State machine states: IDLE, SAMPLE, CHECK, WAIT_OCC, COMMIT.
- IDLE: when spawn_req=1, go to SAMPLE. On the same edge, clear apple_valid and clear the try counter. Otherwise hold.
- SAMPLE: latch cand_col=randX[5:0] and cand_row=randY[5:0]. Go to CHECK.
  - The LFSR advances every cycle, so successive samples differ.
- CHECK: the candidate is illegal if any of the following hold:
  - cand_col==0
  - cand_col>=COLS-1
  - cand_row==0
  - cand_row>=ROWS-1
- CHECK, illegal candidate: treat as a reject.
- CHECK, legal candidate: load occ_x/occ_y with the candidate, set occ_req=1, go to WAIT_OCC.
- WAIT_OCC: hold occ_req, occ_x and occ_y stable until occ_ack.
  - On occ_ack with occ_hit=1: treat as a reject.
  - On occ_ack with occ_hit=0: go to COMMIT.
  - On the ack edge, occ_req drops to 0.
- Reject handling:
  - Increment the try counter.
  - If the new count equals MAX_TRIES: pulse fail, go to IDLE, leave apple_valid=0 and appleX/appleY unchanged.
  - Otherwise go to SAMPLE.
- COMMIT:
  - appleX = cand_col*CELL, truncated to 10 bits.
  - appleY = cand_row*CELL, truncated to 9 bits.
  - Set apple_valid=1, pulse done, go to IDLE.
- The try counter is sized to hold MAX_TRIES (clog2(MAX_TRIES)+1 bits) and never wraps.
- spawn_req outside IDLE is ignored and not queued.
- occ_ack while occ_req=0 is ignored.
- done and fail are never high in the same cycle.

## Timing

- Reset values:
  - state = IDLE
  - appleX=0, appleY=0
  - apple_valid=0, done=0, fail=0
  - occ_req=0, occ_x=0, occ_y=0
  - try counter = 0
- All outputs are registered.
- Reset mid-operation (any state) returns everything to the reset values on the next edge. An occ_ack arriving afterwards is ignored.
- Edge numbering below starts at the edge that samples spawn_req (edge 0):
  - edge 0: state becomes SAMPLE, apple_valid falls.
  - edge 1: candidate latched.
  - edge 2: occ_req rises.
- Zero-wait responder: asserts occ_ack in the first cycle occ_req is high, so the ack is sampled at edge 3.
- Best-case latency: done and apple_valid are high after edge 4.
- Each wall reject adds 2 cycles (SAMPLE, CHECK).
- Each occupancy reject adds 2 cycles plus the responder wait.

## Test plan

- Reset check: assert reset for 3 cycles mid-run, including during WAIT_OCC -> every output matches its reset value. A late occ_ack has no effect.
- Clean placement: randX=0x0A5, randY=0x014, zero-wait ack with occ_hit=0 -> occ_x=37, occ_y=20. After edge 4: appleX=370, appleY=200, apple_valid=1, done high for exactly 1 cycle.
- Wall and off-grid rejects: first sample has row 50, second has col 0, third is (10,10) -> no occ_req for the first two. apple ends at (100,100). done arrives 4 cycles later than best case.
- Occupied retry: first candidate (5,5) answered with occ_hit=1 after a 3-cycle ack delay; next candidate (7,9) is free -> occ_x/occ_y stay stable throughout the wait. Result appleX=70, appleY=90.
- Exhaustion: answer every query with occ_hit=1 -> fail pulses once after the 16th reject. apple_valid=0, appleX/appleY unchanged, state returns to IDLE and accepts a new spawn_req.
- Busy ignore: assert spawn_req again during WAIT_OCC -> exactly one done. No second placement starts.
